// File: rtl/pipe_scoreboard_pkg.sv
// Shared constants and helpers for the pipeline hazard scoreboard.
// Stage indices count from the first stage after ID (EX=1) to write-back.
package pipe_scoreboard_pkg;

    localparam int FWD_RF             = 0;  // forward select meaning "use the register file"
    localparam int REG_ZERO           = 0;  // hard-wired zero register, never a real dependency
    localparam int STG_EX             = 1;
    localparam int STG_MEM            = 2;
    localparam int STG_WB             = 3;
    localparam int DEFAULT_NUM_STAGES = STG_WB;

    // A writer's result can appear no earlier than EX and no later than the last tracked stage.
    function automatic int clamp_lat(input int lat, input int num_stages);
        if (lat < 1) begin
            return 1;
        end
        if (lat > num_stages) begin
            return num_stages;
        end
        return lat;
    endfunction

endpackage

// File: rtl/sb_operand_check.sv
// Priority match of one source operand against the in-flight writer entries.
// Produces the bypass stage to read from, or a hazard if the youngest producer is not ready.
module sb_operand_check
    import pipe_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int REG_AW     = 5,
    parameter int SW         = $clog2(NUM_STAGES + 1)
) (
    input  logic                             uses,
    input  logic [REG_AW-1:0]                src,
    input  logic [NUM_STAGES:1]              ent_valid,
    input  logic [NUM_STAGES:1][REG_AW-1:0]  ent_rd,
    input  logic [NUM_STAGES:1][SW-1:0]      ent_cnt,
    output logic [SW-1:0]                    fwd_sel,
    output logic                             hazard
);

    // Scan from the oldest stage down so the youngest (lowest k) match is the last one written.
    // A pending match still reports its stage; the hazard flag tells ID not to consume it.
    always_comb begin
        fwd_sel = SW'(FWD_RF);
        hazard  = 1'b0;
        if (uses && (src != REG_AW'(REG_ZERO))) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (ent_valid[k] && (ent_rd[k] == src)) begin
                    fwd_sel = SW'(k);
                    hazard  = (ent_cnt[k] != '0);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard: a shift register of in-flight GPR writers, each with its own result countdown,
// checked against both ID source operands to produce bypass selects, a stall and a stall counter.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter  int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter  int REG_AW     = 5,
    parameter  int CNT_W      = 32,
    localparam int SW         = $clog2(NUM_STAGES + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Issue_Valid,
    input  logic [REG_AW-1:0] Issue_Rs,
    input  logic [REG_AW-1:0] Issue_Rt,
    input  logic              Issue_UsesRs,
    input  logic              Issue_UsesRt,
    input  logic              Issue_RegWrite,
    input  logic [REG_AW-1:0] Issue_Rd,
    input  logic [SW-1:0]     Issue_Lat,
    input  logic              Flush,
    output logic              Stall,
    output logic [SW-1:0]     FwdSelRs,
    output logic [SW-1:0]     FwdSelRt,
    output logic [CNT_W-1:0]  StallCount
);

    // Issue handshake: ID offers an instruction with Issue_Valid; it is accepted on a rising
    // clock edge where Stall=0 and Flush=0, otherwise a bubble enters stage 1 that cycle.

    logic [NUM_STAGES:1]             valid_q, valid_d;
    logic [NUM_STAGES:1][REG_AW-1:0] rd_q, rd_d;
    logic [NUM_STAGES:1][SW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]                stall_count_q, stall_count_d;

    logic        hazard_rs;
    logic        hazard_rt;
    logic        insert;
    logic [SW-1:0] ins_cnt;

    sb_operand_check #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SW         (SW)
    ) u_check_rs (
        .uses      (Issue_UsesRs),
        .src       (Issue_Rs),
        .ent_valid (valid_q),
        .ent_rd    (rd_q),
        .ent_cnt   (cnt_q),
        .fwd_sel   (FwdSelRs),
        .hazard    (hazard_rs)
    );

    sb_operand_check #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SW         (SW)
    ) u_check_rt (
        .uses      (Issue_UsesRt),
        .src       (Issue_Rt),
        .ent_valid (valid_q),
        .ent_rd    (rd_q),
        .ent_cnt   (cnt_q),
        .fwd_sel   (FwdSelRt),
        .hazard    (hazard_rt)
    );

    assign Stall      = Issue_Valid && !Flush && (hazard_rs || hazard_rt);
    assign StallCount = stall_count_q;

    always_comb begin
        insert  = Issue_Valid && Issue_RegWrite && (Issue_Rd != REG_AW'(REG_ZERO)) && !Stall && !Flush;
        ins_cnt = SW'(clamp_lat(int'(Issue_Lat), NUM_STAGES) - 1);

        valid_d = '0;
        rd_d    = '0;
        cnt_d   = '0;

        if (insert) begin
            valid_d[STG_EX] = 1'b1;
            rd_d[STG_EX]    = Issue_Rd;
            cnt_d[STG_EX]   = ins_cnt;
        end

        // Entries age one stage per cycle; the last stage falls off into the register file.
        for (int k = STG_EX + 1; k <= NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            cnt_d[k]   = (cnt_q[k-1] != '0) ? (cnt_q[k-1] - SW'(1)) : '0;
        end

        stall_count_d = stall_count_q;
        if (Stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_q       <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed checks of the hazard scoreboard at the default depth (3) and at depth 5.
module tb_pipe_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        urs;
  logic        urt;
  logic        rw;
  logic [4:0]  rd;
  logic [2:0]  lat;
  logic        flush;

  logic        stall3;
  logic [1:0]  fs_rs3;
  logic [1:0]  fs_rt3;
  logic [31:0] cnt3;
  logic        stall5;
  logic [2:0]  fs_rs5;
  logic [2:0]  fs_rt5;
  logic [31:0] cnt5;

  int n_tests;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  pipe_scoreboard #(.NUM_STAGES(3)) dut3 (
    .Clk            (clk),
    .Rst            (rst_n),
    .Issue_Valid    (valid),
    .Issue_Rs       (rs),
    .Issue_Rt       (rt),
    .Issue_UsesRs   (urs),
    .Issue_UsesRt   (urt),
    .Issue_RegWrite (rw),
    .Issue_Rd       (rd),
    .Issue_Lat      (lat[1:0]),
    .Flush          (flush),
    .Stall          (stall3),
    .FwdSelRs       (fs_rs3),
    .FwdSelRt       (fs_rt3),
    .StallCount     (cnt3)
  );

  pipe_scoreboard #(.NUM_STAGES(5)) dut5 (
    .Clk            (clk),
    .Rst            (rst_n),
    .Issue_Valid    (valid),
    .Issue_Rs       (rs),
    .Issue_Rt       (rt),
    .Issue_UsesRs   (urs),
    .Issue_UsesRt   (urt),
    .Issue_RegWrite (rw),
    .Issue_Rd       (rd),
    .Issue_Lat      (lat),
    .Flush          (flush),
    .Stall          (stall5),
    .FwdSelRs       (fs_rs5),
    .FwdSelRt       (fs_rt5),
    .StallCount     (cnt5)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One call = one cycle: inputs change just after the falling edge, checks follow 1 time unit later.
  task automatic drive(input logic v, input logic [4:0] rs_i, input logic urs_i,
                       input logic [4:0] rt_i, input logic urt_i, input logic rw_i,
                       input logic [4:0] rd_i, input logic [2:0] lat_i, input logic flush_i);
    @(negedge clk);
    valid = v;
    rs    = rs_i;
    urs   = urs_i;
    rt    = rt_i;
    urt   = urt_i;
    rw    = rw_i;
    rd    = rd_i;
    lat   = lat_i;
    flush = flush_i;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic writer(input logic [4:0] rd_i, input logic [2:0] lat_i);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd_i, lat_i, 1'b0);
  endtask

  task automatic reader(input logic [4:0] rs_i, input logic urs_i, input logic [4:0] rt_i, input logic urt_i);
    drive(1'b1, rs_i, urs_i, rt_i, urt_i, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    valid = 1'b0; rs = '0; rt = '0; urs = 1'b0; urt = 1'b0;
    rw = 1'b0; rd = '0; lat = '0; flush = 1'b0;

    // reset state
    idle(2);
    check_eq("rst_stall3", 32'(stall3), 32'd0);
    check_eq("rst_fsrs3",  32'(fs_rs3), 32'd0);
    check_eq("rst_fsrt3",  32'(fs_rt3), 32'd0);
    check_eq("rst_cnt3",   cnt3,        32'd0);
    check_eq("rst_cnt5",   cnt5,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ALU chain, result walks through EX, MEM, WB then retires
    writer(5'd8, 3'd1);
    check_eq("t1_prod_stall", 32'(stall3), 32'd0);
    reader(5'd8, 1'b1, 5'd0, 1'b0);
    check_eq("t1_c1_stall", 32'(stall3), 32'd0);
    check_eq("t1_c1_fsrs",  32'(fs_rs3), 32'd1);
    reader(5'd8, 1'b1, 5'd0, 1'b0);
    check_eq("t1_c2_fsrs",  32'(fs_rs3), 32'd2);
    reader(5'd8, 1'b1, 5'd0, 1'b0);
    check_eq("t1_c3_fsrs_wb", 32'(fs_rs3), 32'd3);
    reader(5'd8, 1'b1, 5'd0, 1'b0);
    check_eq("t1_c4_fsrs_rf", 32'(fs_rs3), 32'd0);
    idle(3);

    // 2: load-use, one stall cycle then forward from MEM
    writer(5'd9, 3'd2);
    reader(5'd0, 1'b0, 5'd9, 1'b1);
    check_eq("t2_stall_on",  32'(stall3), 32'd1);
    check_eq("t2_cnt_before", cnt3,       32'd0);
    reader(5'd0, 1'b0, 5'd9, 1'b1);
    check_eq("t2_stall_off", 32'(stall3), 32'd0);
    check_eq("t2_fsrt",      32'(fs_rt3), 32'd2);
    check_eq("t2_cnt",       cnt3,        32'd1);
    idle(3);

    // 3: two writers of the same register, the younger one wins
    writer(5'd10, 3'd1);
    writer(5'd10, 3'd1);
    reader(5'd10, 1'b1, 5'd0, 1'b0);
    check_eq("t3_fsrs_young", 32'(fs_rs3), 32'd1);
    check_eq("t3_stall",      32'(stall3), 32'd0);
    idle(3);

    // 4: zero register and unused operands never match
    writer(5'd0, 3'd3);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd11, 3'd1, 1'b0);
    check_eq("t4_zero_stall", 32'(stall3), 32'd0);
    check_eq("t4_zero_fsrs",  32'(fs_rs3), 32'd0);
    check_eq("t4_zero_fsrt",  32'(fs_rt3), 32'd0);
    reader(5'd11, 1'b1, 5'd11, 1'b0);
    check_eq("t4_used_fsrs",   32'(fs_rs3), 32'd1);
    check_eq("t4_unused_fsrt", 32'(fs_rt3), 32'd0);
    idle(3);

    // 5: flush masks the hazard and its own write
    writer(5'd12, 3'd3);
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, 3'd1, 1'b1);
    check_eq("t5_flush_stall", 32'(stall3), 32'd0);
    reader(5'd13, 1'b1, 5'd12, 1'b1);
    check_eq("t5_bubble_fsrs", 32'(fs_rs3), 32'd0);
    check_eq("t5_stall_after", 32'(stall3), 32'd1);
    check_eq("t5_cnt_held",    cnt3,        32'd1);
    reader(5'd13, 1'b1, 5'd12, 1'b1);
    check_eq("t5_release",     32'(stall3), 32'd0);
    check_eq("t5_fsrt_wb",     32'(fs_rt3), 32'd3);
    check_eq("t5_cnt",         cnt3,        32'd2);
    idle(5);

    // 6: deep pipe, madd latency 4 -> three stall cycles, then forward from stage 4
    check_eq("t6_cnt5_start", cnt5, 32'd2);
    writer(5'd14, 3'd4);
    for (int i = 0; i < 3; i++) begin
      reader(5'd14, 1'b1, 5'd0, 1'b0);
      check_eq($sformatf("t6_stall_%0d", i), 32'(stall5), 32'd1);
    end
    reader(5'd14, 1'b1, 5'd0, 1'b0);
    check_eq("t6_release", 32'(stall5), 32'd0);
    check_eq("t6_fsrs",    32'(fs_rs5), 32'd4);
    check_eq("t6_cnt5",    cnt5,        32'd5);

    // asynchronous reset in the middle of a stall
    writer(5'd15, 3'd4);
    reader(5'd15, 1'b1, 5'd0, 1'b0);
    check_eq("t6_stall_pre_rst", 32'(stall5), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_stall", 32'(stall5), 32'd0);
    check_eq("t6_rst_cnt5",  cnt5,        32'd0);
    check_eq("t6_rst_fsrs",  32'(fs_rs5), 32'd0);
    check_eq("t6_rst_cnt3",  cnt3,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reader(5'd15, 1'b1, 5'd0, 1'b0);
    check_eq("t6_post_stall", 32'(stall5), 32'd0);
    check_eq("t6_post_cnt5",  cnt5,        32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
